// File: rtl/hazard_response_ctrl.sv
// Consumes the ID-stage stall and redirect requests and turns them into pipeline write-enables,
// bubble and flush controls. It also runs a consecutive-stall watchdog and stall/flush counters.
module hazard_response_ctrl #(
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallSignal,
    input  logic             lw_use_stall,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             PCWrite,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             stall_active,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, STALL, TIMEOUT} stateT;

    localparam logic [4:0]       maxStallLen = 5'(MAX_STALL);
    localparam logic [CNT_W-1:0] cntMax      = {CNT_W{1'b1}};

    stateT      state, nextState;
    logic [3:0] runLen, nextRunLen;
    logic [4:0] runLenInc;
    logic       stallReq, redirect;

    assign stallReq  = stallSignal | lw_use_stall;
    assign redirect  = (branch_taken | jump) & ~stallReq;
    assign runLenInc = {1'b0, runLen} + 5'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RUN;
            runLen <= 4'd0;
        end else begin
            state  <= nextState;
            runLen <= nextRunLen;
        end
    end

    // TIMEOUT is sticky; only reset brings the FSM back to RUN.
    always_comb begin
        nextState  = state;
        nextRunLen = 4'd0;
        if (stallReq) begin
            nextRunLen = (runLen == 4'hF) ? 4'hF : runLen + 4'd1;
        end
        case (state)
            RUN: begin
                if (stallReq) begin
                    nextState = STALL;
                end
            end
            STALL: begin
                if (!stallReq) begin
                    nextState = RUN;
                end else if (runLenInc > maxStallLen) begin
                    nextState = TIMEOUT;
                end
            end
            TIMEOUT: nextState = TIMEOUT;
            default: nextState = RUN;
        endcase
    end

    // Pipeline controls follow the live requests so the watchdog never overrides them.
    always_comb begin
        PCWrite       = ~reset & ~stallReq;
        IF_ID_write   = ~reset & ~stallReq;
        ID_EX_bubble  = reset | stallReq;
        IF_ID_flush   = reset | redirect;
        stall_timeout = (state == TIMEOUT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_active <= 1'b0;
            stall_count  <= '0;
            flush_count  <= '0;
        end else begin
            stall_active <= stallReq;
            if (stallReq && (stall_count != cntMax)) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (redirect && (flush_count != cntMax)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_response_ctrl.sv
// Directed bench for hazard_response_ctrl; the driver queues hand-computed expectations,
// the monitor pops and compares one entry per cycle at the falling edge.
module tb_hazard_response_ctrl;

    logic       clk;
    logic       reset;
    logic       stallSignal, lwUseStall, branchTaken, jump;
    logic       pcWrite, ifIdWrite, ifIdFlush, idExBubble, stallActive, stallTimeout;
    logic [3:0] stallCount, flushCount;

    int total = 0;
    int bad   = 0;

    logic [13:0] expQ[$];
    string       nameQ[$];

    hazard_response_ctrl #(.CNT_W(4), .MAX_STALL(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .stallSignal  (stallSignal),
        .lw_use_stall (lwUseStall),
        .branch_taken (branchTaken),
        .jump         (jump),
        .PCWrite      (pcWrite),
        .IF_ID_write  (ifIdWrite),
        .IF_ID_flush  (ifIdFlush),
        .ID_EX_bubble (idExBubble),
        .stall_active (stallActive),
        .stall_timeout(stallTimeout),
        .stall_count  (stallCount),
        .flush_count  (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctl = {PCWrite, IF_ID_write, IF_ID_flush, ID_EX_bubble} for this cycle's inputs;
    // the rest are register values as left by the previous edge.
    task automatic applyStimulus(input string name, input logic rst, input logic ss,
                                 input logic lw, input logic bt, input logic jp,
                                 input logic [3:0] ctl, input logic sa, input logic to,
                                 input logic [3:0] sc, input logic [3:0] fc);
        @(posedge clk);
        #1;
        reset       = rst;
        stallSignal = ss;
        lwUseStall  = lw;
        branchTaken = bt;
        jump        = jp;
        expQ.push_back({ctl, sa, to, sc, fc});
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input logic [13:0] want, input string name);
        logic [13:0] got;
        got = {pcWrite, ifIdWrite, ifIdFlush, idExBubble, stallActive, stallTimeout,
               stallCount, flushCount};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%b want=%b (pcw ifw fl bb sa to sc fc)", name, got, want);
        end
    endtask

    initial begin
        logic [13:0] e;
        string       n;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                n = nameQ.pop_front();
                checkOutput(e, n);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        stallSignal = 1'b0;
        lwUseStall  = 1'b0;
        branchTaken = 1'b0;
        jump        = 1'b0;
        @(posedge clk);

        applyStimulus("reset1",   1, 0, 0, 0, 0, 4'b0011, 0, 0, 4'd0, 4'd0);
        applyStimulus("reset2",   1, 0, 0, 0, 0, 4'b0011, 0, 0, 4'd0, 4'd0);
        applyStimulus("idle1",    0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd0, 4'd0);
        applyStimulus("idle2",    0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd0, 4'd0);

        applyStimulus("stallA1",  0, 1, 0, 0, 0, 4'b0001, 0, 0, 4'd0, 4'd0);
        applyStimulus("stallA2",  0, 1, 0, 0, 0, 4'b0001, 1, 0, 4'd1, 4'd0);
        applyStimulus("stallAend",0, 0, 0, 0, 0, 4'b1100, 1, 0, 4'd2, 4'd0);
        applyStimulus("stallAidl",0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd2, 4'd0);

        applyStimulus("brStall",  0, 1, 0, 1, 0, 4'b0001, 0, 0, 4'd2, 4'd0);
        applyStimulus("brTaken",  0, 0, 0, 1, 0, 4'b1110, 1, 0, 4'd3, 4'd0);
        applyStimulus("brAfter",  0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd3, 4'd1);

        applyStimulus("lwUse1",   0, 0, 1, 0, 0, 4'b0001, 0, 0, 4'd3, 4'd1);
        applyStimulus("lwUse2",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd4, 4'd1);
        applyStimulus("lwUse3",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd5, 4'd1);
        applyStimulus("lwUse4",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd6, 4'd1);
        applyStimulus("lwUse5",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd7, 4'd1);
        applyStimulus("lwUse6",   0, 0, 1, 0, 0, 4'b0001, 1, 1, 4'd8, 4'd1);
        applyStimulus("toSticky1",0, 0, 0, 0, 0, 4'b1100, 1, 1, 4'd9, 4'd1);
        applyStimulus("toSticky2",0, 0, 0, 0, 0, 4'b1100, 0, 1, 4'd9, 4'd1);

        applyStimulus("rstMid1",  0, 1, 0, 0, 0, 4'b0001, 0, 1, 4'd9, 4'd1);
        applyStimulus("rstMid2",  0, 1, 0, 0, 0, 4'b0001, 1, 1, 4'd10, 4'd1);
        applyStimulus("rstMid3",  1, 1, 0, 0, 0, 4'b0011, 1, 1, 4'd11, 4'd1);
        applyStimulus("rstAfter", 0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd0, 4'd0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus("jumpSat", 0, 0, 0, 0, 1, 4'b1110, 0, 0, 4'd0,
                          (i > 15) ? 4'd15 : 4'(i));
        end
        applyStimulus("jumpEnd",  0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd0, 4'd15);

        applyStimulus("edge4a",   0, 0, 1, 0, 0, 4'b0001, 0, 0, 4'd0, 4'd15);
        applyStimulus("edge4b",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd1, 4'd15);
        applyStimulus("edge4c",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd2, 4'd15);
        applyStimulus("edge4d",   0, 0, 1, 0, 0, 4'b0001, 1, 0, 4'd3, 4'd15);
        applyStimulus("edge4end", 0, 0, 0, 0, 0, 4'b1100, 1, 0, 4'd4, 4'd15);
        applyStimulus("edge4idl", 0, 0, 0, 0, 0, 4'b1100, 0, 0, 4'd4, 4'd15);

        for (int i = 0; i < 5 && expQ.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: pending=%0d want=0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_response_ctrl.md
Name: hazard_response_ctrl

Overview:
- Consumer side of the ID-stage hazard detectors in the 5-stage MIPS pipeline.
- Takes the combinational stall requests (branch-operand stall, load-use stall) and the ID-stage branch/jump resolution, and drives the pipeline write-enables, bubble and flush controls.
- Keeps the consecutive-stall FSM, a stall-timeout watchdog and saturating stall/flush performance counters.

Parameters:
- CNT_W, 16, width of stall_count and flush_count.
- MAX_STALL, 4, max consecutive stall cycles before a timeout is flagged (legal range 1..15).

Ports:
- clk  input  1  pipeline clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high.
- stallSignal  input  1  branch-operand stall request from ID (lw or R-type producer ahead of beq).
- lw_use_stall  input  1  generic load-use stall request from ID.
- branch_taken  input  1  ID comparator result for a beq/bne in ID, meaningful only when not stalling.
- jump  input  1  j/jal decoded in ID.
- PCWrite  output  1  PC register write enable.
- IF_ID_write  output  1  IF/ID register write enable.
- IF_ID_flush  output  1  zero the IF/ID register at the next edge.
- ID_EX_bubble  output  1  zero control fields entering ID/EX at the next edge.
- stall_active  output  1  registered, 1 while the FSM is in STALL.
- stall_timeout  output  1  sticky watchdog flag.
- stall_count  output  CNT_W  saturating count of stalled cycles.
- flush_count  output  CNT_W  saturating count of flushes.

Behaviour:
- stall_req = stallSignal | lw_use_stall. redirect = (branch_taken | jump) & ~stall_req.
- Control outputs are combinational from the current inputs and state. Detectors resolve in the same cycle, so a stall takes effect with zero latency:
  - PCWrite = IF_ID_write = ~reset & ~stall_req
  - ID_EX_bubble = reset | stall_req
  - IF_ID_flush = reset | redirect
- Priority is reset > stall > redirect. A branch_taken or jump seen while stall_req=1 is ignored that cycle. It is honoured in the first cycle stall_req drops, provided ID still holds it.
- When stall and redirect coincide: no flush, no PC write. The stalled branch re-evaluates next cycle.
- FSM state register (binary), next state updated on each edge:
  - RUN (reset state): stall_req=1 -> STALL, run_len=1. Otherwise stay in RUN.
  - STALL: stall_req=1 -> run_len+1. If run_len+1 > MAX_STALL -> TIMEOUT. stall_req=0 -> RUN, run_len=0.
  - TIMEOUT: stall_timeout=1 and sticky. Outputs still follow stall_req, so the watchdog flags but never overrides. Leaves only on reset.
- run_len is 4 bits and saturates at 15.
- stall_active = 1 exactly in STALL and TIMEOUT when entered through a stall. It is registered and lags stall_req by one cycle.
- stall_count increments on every edge where stall_req=1 and reset=0.
- flush_count increments on every edge where redirect=1 and reset=0.
- Both counters saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-stall or mid-flush, for every edge where reset=1:
  - State goes to RUN; run_len, stall_count, flush_count and stall_timeout go to 0; stall_active goes to 0.
  - While reset=1: PCWrite=0, IF_ID_write=0, ID_EX_bubble=1, IF_ID_flush=1.
- X on stall inputs is not tolerated; inputs are assumed to come from registered/decoded ID signals.

Test Plan:
- Reset 2 cycles, then idle inputs 0 -> during reset PCWrite=0, IF_ID_flush=1, ID_EX_bubble=1. After reset PCWrite=1, IF_ID_write=1, flush=0, bubble=0, counters 0, stall_active=0.
- stallSignal=1 for 2 cycles (lw then beq) -> PCWrite/IF_ID_write=0 and ID_EX_bubble=1 in exactly those 2 cycles. stall_active high the 2 cycles following each assertion edge. stall_count=2. No timeout.
- branch_taken=1 together with stallSignal=1 for 1 cycle, then branch_taken=1 alone -> cycle 1: no flush, flush_count=0. Cycle 2: IF_ID_flush=1, PCWrite=1, flush_count=1.
- lw_use_stall=1 held 6 cycles with MAX_STALL=4 -> stall_timeout rises after the 5th stalled edge and stays 1 after the stall ends. PCWrite still tracks stall_req. stall_count=6.
- Reset asserted during the 3rd stall cycle -> next edge: all counters 0, stall_timeout=0, state RUN. PCWrite=0 while reset=1, then 1 once reset=0 and stall inputs are 0.
- CNT_W=4, jump=1 for 20 cycles -> flush_count saturates at 15. IF_ID_flush=1 every cycle.
